// File: rtl/tap_bank_select_pkg.sv
// tap_bank_select_pkg
// Shared helpers for the tap bank selector. Window generators, the selector
// and the MAC array all use these so that they agree on how taps and banks
// are packed into the flat data buses.
//   sel_width : width of a bank index for a given bank count
//   tap_lsb   : lsb of tap t of bank b in a flat {bank, tap} bus
//   bank_lsb  : lsb of the first tap of bank b in a flat {bank, tap} bus
package tap_bank_select_pkg;

   // A bank index needs at least one bit, even for the degenerate case.
   function automatic int sel_width(input int banks);
      return (banks < 2) ? 1 : $clog2(banks);
   endfunction

   // Bank b, tap t sits at [(b*taps + t)*width +: width].
   function automatic int tap_lsb(input int bank, input int tap, input int taps, input int width);
      return (bank * taps + tap) * width;
   endfunction

   // A whole bank is taps*width contiguous bits, tap 0 at the bottom.
   function automatic int bank_lsb(input int bank, input int taps, input int width);
      return bank * taps * width;
   endfunction

endpackage

// File: rtl/tap_bank_select_if.sv
// tap_bank_select_if
// Upstream/downstream bundle of the tap bank selector.
//   in_data   : BANKS*TAPS*WIDTH candidate taps from the window generator
//   in_sel    : bank index for this beat (ignored in round-robin mode)
//   in_valid  : upstream beat valid
//   in_ready  : selector can take a beat (registered, equals skid empty)
//   ptr_clr   : clear of the round-robin pointer
//   out_data  : TAPS*WIDTH selected taps
//   out_bank  : bank that produced out_data
//   out_valid : output beat valid
//   out_ready : downstream accepts the beat
//   sel_err   : sticky flag, an out-of-range in_sel was accepted
// master is the side that drives beats in and takes them out (the
// surrounding datapath); slave is the selector itself.
interface tap_bank_select_if
   import tap_bank_select_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int TAPS  = 4,
   parameter int BANKS = 2,
   parameter int SEL_W = sel_width(BANKS)
);

   logic [BANKS*TAPS*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]            in_sel;
   logic                        in_valid;
   logic                        in_ready;
   logic                        ptr_clr;
   logic [TAPS*WIDTH-1:0]       out_data;
   logic [SEL_W-1:0]            out_bank;
   logic                        out_valid;
   logic                        out_ready;
   logic                        sel_err;

   modport master (
      output in_data, in_sel, in_valid, ptr_clr, out_ready,
      input  in_ready, out_data, out_bank, out_valid, sel_err
   );

   modport slave (
      input  in_data, in_sel, in_valid, ptr_clr, out_ready,
      output in_ready, out_data, out_bank, out_valid, sel_err
   );

endinterface

// File: rtl/tap_bank_select_skid_reg.sv
// skid_reg
// Generic two-entry valid/ready register stage: a main output register plus
// one skid entry. Every output is a flop, so there is no combinational path
// from in_* to out_* nor from out_ready to in_ready.
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/valid/ready : upstream side, in_ready is "skid empty"
//   out_data/valid/ready: downstream side
module skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] skid_q;
   logic             out_valid_q;
   logic             skid_valid_q;
   logic             skid_valid_d;
   logic             in_ready_q;
   logic             accept;
   logic             load_out;

   assign accept   = in_valid & in_ready_q;
   assign load_out = ~out_valid_q | out_ready;

   // Next skid occupancy. Whenever the output register can load, the skid
   // (if full) is the oldest beat and moves forward, so the skid ends up
   // empty; a new beat only lands in the skid while the output is stalled.
   // in_ready_q is never high with the skid full, so no overwrite can occur.
   always_comb begin
      skid_valid_d = skid_valid_q;
      if (load_out) begin
         skid_valid_d = 1'b0;
      end else if (accept) begin
         skid_valid_d = 1'b1;
      end
   end

   // Data movement. Priority skid -> output over input -> output keeps
   // order. in_ready is held low through reset and rises on the first edge
   // afterwards because the skid is empty then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         if (load_out) begin
            if (skid_valid_q) begin
               out_q       <= skid_q;
               out_valid_q <= 1'b1;
            end else if (accept) begin
               out_q       <= in_data;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_q <= in_data;
         end
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= ~skid_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_data  = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: rtl/tap_bank_select.sv
// tap_bank_select
// Picks one of BANKS groups of TAPS samples per beat and forwards it, with
// the bank index, through a registered valid/ready stage with a skid entry.
// Feeds the bicubic MAC array from the pixel/coefficient window generators.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of tap_bank_select_if (beats, select, pointer
//                clear, selected output, sticky select error)
// AUTO = 0 takes the bank from in_sel; AUTO = 1 uses an internal
// round-robin pointer and ignores in_sel.
module tap_bank_select
   import tap_bank_select_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int TAPS  = 4,
   parameter int BANKS = 2,
   parameter int AUTO  = 0,
   parameter int SEL_W = sel_width(BANKS)
) (
   input logic              clk,
   input logic              reset,
   tap_bank_select_if.slave bus
);

   localparam int BANK_W  = TAPS * WIDTH;
   localparam int ENTRY_W = SEL_W + BANK_W;

   logic [SEL_W-1:0]   ptr_q;
   logic [SEL_W-1:0]   bank_sel;
   logic               sel_bad;
   logic               sel_err_q;
   logic               in_ready;
   logic               accept;
   logic [BANK_W-1:0]  bank_data;
   logic [ENTRY_W-1:0] skid_out;

   assign accept = bus.in_valid & in_ready;

   // Bank choice for the beat on the input. An out-of-range explicit select
   // falls back to bank 0 so the MAC array always sees real samples.
   always_comb begin
      sel_bad  = 1'b0;
      bank_sel = '0;
      if (AUTO != 0) begin
         bank_sel = ptr_q;
      end else if (int'(bus.in_sel) >= BANKS) begin
         sel_bad = 1'b1;
      end else begin
         bank_sel = bus.in_sel;
      end
   end

   // Bank mux: the chosen bank's taps are already in output order, so the
   // whole bank slice is forwarded untouched.
   always_comb begin
      bank_data = bus.in_data[BANK_W-1:0];
      for (int b = 1; b < BANKS; b++) begin
         if (int'(bank_sel) == b) begin
            bank_data = bus.in_data[bank_lsb(b, TAPS, WIDTH) +: BANK_W];
         end
      end
   end

   // Round-robin pointer. A clear on the same edge as an accept lets that
   // beat use the current pointer, then restarts from 0 (clear beats
   // increment).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (AUTO != 0) begin
         if (bus.ptr_clr) begin
            ptr_q <= '0;
         end else if (accept) begin
            ptr_q <= (ptr_q == SEL_W'(BANKS - 1)) ? '0 : ptr_q + SEL_W'(1);
         end
      end
   end

   // Sticky select error, only cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_err_q <= 1'b0;
      end else if (accept && sel_bad) begin
         sel_err_q <= 1'b1;
      end
   end

   skid_reg #(
      .WIDTH(ENTRY_W)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .in_data  ({bank_sel, bank_data}),
      .in_valid (bus.in_valid),
      .in_ready (in_ready),
      .out_data (skid_out),
      .out_valid(bus.out_valid),
      .out_ready(bus.out_ready)
   );

   assign bus.in_ready = in_ready;
   assign bus.out_bank = skid_out[ENTRY_W-1 -: SEL_W];
   assign bus.out_data = skid_out[BANK_W-1:0];
   assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_tap_bank_select.sv
// tb_tap_bank_select
// Bench for tap_bank_select. Four instances cover the configurations of
// interest: explicit select with 2, 3 and 4 banks, and round-robin with 3.
// Accepted beats are pushed to a per-instance expectation queue and popped
// when the instance hands a beat downstream.
module tb_tap_bank_select;

   localparam int W  = 17;
   localparam int T  = 4;
   localparam int DW = T * W;
   localparam int AW = 4 * DW;

   typedef struct {
      logic [DW-1:0] data;
      int            bank;
   } exp_t;

   typedef struct {
      int sel;
      int bank;
      bit err;
   } sel_vec_t;

   typedef struct {
      bit clr;
      int bank;
   } auto_vec_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   tap_bank_select_if #(.WIDTH(W), .TAPS(T), .BANKS(2)) b2 ();
   tap_bank_select_if #(.WIDTH(W), .TAPS(T), .BANKS(3)) ba ();
   tap_bank_select_if #(.WIDTH(W), .TAPS(T), .BANKS(3)) b3 ();
   tap_bank_select_if #(.WIDTH(W), .TAPS(T), .BANKS(4)) b4 ();

   tap_bank_select #(.WIDTH(W), .TAPS(T), .BANKS(2), .AUTO(0)) u_b2 (.clk(clk), .reset(reset), .bus(b2));
   tap_bank_select #(.WIDTH(W), .TAPS(T), .BANKS(3), .AUTO(1)) u_ba (.clk(clk), .reset(reset), .bus(ba));
   tap_bank_select #(.WIDTH(W), .TAPS(T), .BANKS(3), .AUTO(0)) u_b3 (.clk(clk), .reset(reset), .bus(b3));
   tap_bank_select #(.WIDTH(W), .TAPS(T), .BANKS(4), .AUTO(0)) u_b4 (.clk(clk), .reset(reset), .bus(b4));

   int   errors = 0;
   int   checks = 0;
   exp_t q2[$];
   exp_t qa[$];
   exp_t q3[$];
   exp_t q4[$];
   int   pops2 = 0;
   int   popsa = 0;
   int   pops3 = 0;
   int   pops4 = 0;
   int   accepted4 = 0;
   int   auto_bank = 0;
   int   b3_bank = 0;
   int   comb_viol = 0;

   sel_vec_t  sv[6];
   auto_vec_t av[14];

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic unexpectedBeat(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: output beat with empty expectation queue", name);
   endtask

   // Reference selection for explicit-select instances.
   function automatic exp_t model_sel(input logic [AW-1:0] data, input int sel, input int banks);
      exp_t e;
      int   b;
      b      = (sel < banks) ? sel : 0;
      e.bank = b;
      e.data = data[b*DW +: DW];
      return e;
   endfunction

   // Scoreboard: outputs first (older beats), then newly accepted inputs.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (b2.out_valid && b2.out_ready) begin
            if (q2.size() == 0) unexpectedBeat("b2 beat");
            else begin
               e = q2.pop_front();
               checkOutput("b2 data", b2.out_data, e.data);
               checkOutput("b2 bank", DW'(b2.out_bank), DW'(e.bank));
               pops2++;
            end
         end
         if (ba.out_valid && ba.out_ready) begin
            if (qa.size() == 0) unexpectedBeat("auto beat");
            else begin
               e = qa.pop_front();
               checkOutput("auto data", ba.out_data, e.data);
               checkOutput("auto bank", DW'(ba.out_bank), DW'(e.bank));
               popsa++;
            end
         end
         if (b3.out_valid && b3.out_ready) begin
            if (q3.size() == 0) unexpectedBeat("b3 beat");
            else begin
               e = q3.pop_front();
               checkOutput("b3 data", b3.out_data, e.data);
               checkOutput("b3 bank", DW'(b3.out_bank), DW'(e.bank));
               pops3++;
            end
         end
         if (b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) unexpectedBeat("b4 beat");
            else begin
               e = q4.pop_front();
               checkOutput("b4 data", b4.out_data, e.data);
               checkOutput("b4 bank", DW'(b4.out_bank), DW'(e.bank));
               pops4++;
            end
         end
         if (b2.in_valid && b2.in_ready) q2.push_back(model_sel(AW'(b2.in_data), int'(b2.in_sel), 2));
         if (ba.in_valid && ba.in_ready) begin
            e.bank = auto_bank;
            e.data = ba.in_data[auto_bank*DW +: DW];
            qa.push_back(e);
         end
         if (b3.in_valid && b3.in_ready) begin
            e.bank = b3_bank;
            e.data = b3.in_data[b3_bank*DW +: DW];
            q3.push_back(e);
         end
         if (b4.in_valid && b4.in_ready) begin
            q4.push_back(model_sel(AW'(b4.in_data), int'(b4.in_sel), 4));
            accepted4++;
         end
      end
   end

   // Drive one table beat into the 3-bank explicit-select instance.
   task automatic applyStimulus(input sel_vec_t v);
      for (int k = 0; k < 3 * T; k++) b3.in_data[k*W +: W] = W'($urandom);
      b3.in_sel   = 2'(v.sel);
      b3_bank     = v.bank;
      b3.in_valid = 1'b1;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [DW-1:0] a_data, b_data, c_data;
      logic          rdy_before;
      int            cyc;

      sv[0] = '{sel: 1, bank: 1, err: 1'b0};
      sv[1] = '{sel: 2, bank: 2, err: 1'b0};
      sv[2] = '{sel: 0, bank: 0, err: 1'b0};
      sv[3] = '{sel: 3, bank: 0, err: 1'b1};
      sv[4] = '{sel: 1, bank: 1, err: 1'b1};
      sv[5] = '{sel: 2, bank: 2, err: 1'b1};

      av[0]  = '{clr: 1'b0, bank: 0};
      av[1]  = '{clr: 1'b0, bank: 1};
      av[2]  = '{clr: 1'b0, bank: 2};
      av[3]  = '{clr: 1'b0, bank: 0};
      av[4]  = '{clr: 1'b0, bank: 1};
      av[5]  = '{clr: 1'b0, bank: 2};
      av[6]  = '{clr: 1'b0, bank: 0};
      av[7]  = '{clr: 1'b0, bank: 0};
      av[8]  = '{clr: 1'b0, bank: 1};
      av[9]  = '{clr: 1'b0, bank: 2};
      av[10] = '{clr: 1'b0, bank: 0};
      av[11] = '{clr: 1'b1, bank: 1};
      av[12] = '{clr: 1'b0, bank: 0};
      av[13] = '{clr: 1'b0, bank: 1};

      reset = 1'b1;
      b2.in_data = '0; b2.in_sel = '0; b2.in_valid = 1'b0; b2.ptr_clr = 1'b0; b2.out_ready = 1'b0;
      ba.in_data = '0; ba.in_sel = '0; ba.in_valid = 1'b0; ba.ptr_clr = 1'b0; ba.out_ready = 1'b1;
      b3.in_data = '0; b3.in_sel = '0; b3.in_valid = 1'b0; b3.ptr_clr = 1'b0; b3.out_ready = 1'b1;
      b4.in_data = '0; b4.in_sel = '0; b4.in_valid = 1'b0; b4.ptr_clr = 1'b0; b4.out_ready = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst out_valid", DW'(b2.out_valid), DW'(0));
      checkOutput("rst out_data", b2.out_data, DW'(0));
      checkOutput("rst out_bank", DW'(b2.out_bank), DW'(0));
      checkOutput("rst sel_err", DW'(b2.sel_err), DW'(0));
      checkOutput("rst in_ready", DW'(b2.in_ready), DW'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("in_ready after release", DW'(b2.in_ready), DW'(1));

      // First beat: bank 1 of a 2-bank selector
      for (int t = 0; t < T; t++) begin
         b2.in_data[t*W +: W]     = W'(17'h1a0a0 + t);
         b2.in_data[(T+t)*W +: W] = W'(17'h11 * (t + 1));
      end
      b2.in_sel    = 1'b1;
      b2.in_valid  = 1'b1;
      b2.out_ready = 1'b1;
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
      checkOutput("first out_valid", DW'(b2.out_valid), DW'(1));
      checkOutput("first out_data", b2.out_data, {17'h00044, 17'h00033, 17'h00022, 17'h00011});
      checkOutput("first out_bank", DW'(b2.out_bank), DW'(1));
      checkOutput("first sel_err", DW'(b2.sel_err), DW'(0));
      @(posedge clk); #1;
      checkOutput("first drained", DW'(b2.out_valid), DW'(0));

      // Back-pressure: A held, B in skid, C refused until release
      b2.out_ready = 1'b0;
      b2.in_sel    = 1'b0;
      b2.in_valid  = 1'b1;
      for (int k = 0; k < 2 * T; k++) b2.in_data[k*W +: W] = W'($urandom);
      a_data = b2.in_data[DW-1:0];
      @(posedge clk); #1;
      for (int k = 0; k < 2 * T; k++) b2.in_data[k*W +: W] = W'($urandom);
      b_data = b2.in_data[DW-1:0];
      @(posedge clk); #1;
      for (int k = 0; k < 2 * T; k++) b2.in_data[k*W +: W] = W'($urandom);
      c_data = b2.in_data[DW-1:0];
      @(posedge clk); #1;
      checkOutput("bp in_ready low", DW'(b2.in_ready), DW'(0));
      checkOutput("bp A held", b2.out_data, a_data);
      checkOutput("bp out_valid", DW'(b2.out_valid), DW'(1));
      @(posedge clk); #1;
      checkOutput("bp still held", b2.out_data, a_data);
      checkOutput("bp C refused", DW'(b2.in_ready), DW'(0));
      b2.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp B next", b2.out_data, b_data);
      checkOutput("bp no gap B", DW'(b2.out_valid), DW'(1));
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
      checkOutput("bp C next", b2.out_data, c_data);
      checkOutput("bp no gap C", DW'(b2.out_valid), DW'(1));
      @(posedge clk); #1;
      checkOutput("bp drained", DW'(b2.out_valid), DW'(0));
      checkOutput("b2 beat count", DW'(pops2), DW'(4));

      // Round-robin, 3 banks: plain run, lone clear, then clear with 5th beat
      for (int i = 0; i < 14; i++) begin
         if (i == 7) begin
            ba.in_valid = 1'b0;
            ba.ptr_clr  = 1'b1;
            @(posedge clk); #1;
         end
         for (int k = 0; k < 3 * T; k++) ba.in_data[k*W +: W] = W'($urandom);
         ba.in_sel   = 2'($urandom);
         ba.ptr_clr  = av[i].clr;
         auto_bank   = av[i].bank;
         ba.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      ba.in_valid = 1'b0;
      ba.ptr_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("auto beat count", DW'(popsa), DW'(14));
      checkOutput("auto sel_err", DW'(ba.sel_err), DW'(0));

      // Explicit select, 3 banks: out-of-range select and sticky error
      for (int i = 0; i < 6; i++) begin
         applyStimulus(sv[i]);
         @(posedge clk); #1;
         checkOutput($sformatf("b3 sel_err beat %0d", i), DW'(b3.sel_err), DW'(sv[i].err));
      end
      b3.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("b3 sel_err sticky", DW'(b3.sel_err), DW'(1));
      checkOutput("b3 beat count", DW'(pops3), DW'(6));

      // Random traffic, 4 banks
      cyc = 0;
      while (accepted4 < 1000 && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         rdy_before   = b4.in_ready;
         b4.out_ready = 1'($urandom_range(0, 1));
         #1;
         if (b4.in_ready !== rdy_before) comb_viol++;
         b4.in_valid = 1'($urandom_range(0, 1));
         b4.in_sel   = 2'($urandom);
         for (int k = 0; k < 4 * T; k++) b4.in_data[k*W +: W] = W'($urandom);
      end
      b4.in_valid  = 1'b0;
      b4.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("b4 reached 1000 beats", DW'(accepted4 >= 1000), DW'(1));
      checkOutput("b4 all delivered", DW'(pops4), DW'(accepted4));
      checkOutput("b4 queue empty", DW'(q4.size()), DW'(0));
      checkOutput("in_ready vs out_ready", DW'(comb_viol), DW'(0));

      // Asynchronous reset with skid full
      b2.out_ready = 1'b0;
      b2.in_sel    = 1'b1;
      b2.in_valid  = 1'b1;
      for (int k = 0; k < 2 * T; k++) b2.in_data[k*W +: W] = W'($urandom);
      @(posedge clk); #1;
      for (int k = 0; k < 2 * T; k++) b2.in_data[k*W +: W] = W'($urandom);
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
      checkOutput("skid full before reset", DW'(b2.in_ready), DW'(0));
      #2;
      reset = 1'b1;
      q2.delete();
      qa.delete();
      q3.delete();
      q4.delete();
      #1;
      checkOutput("async rst out_valid", DW'(b2.out_valid), DW'(0));
      checkOutput("async rst out_data", b2.out_data, DW'(0));
      checkOutput("async rst out_bank", DW'(b2.out_bank), DW'(0));
      checkOutput("async rst in_ready", DW'(b2.in_ready), DW'(0));
      checkOutput("async rst sel_err", DW'(b3.sel_err), DW'(0));
      @(posedge clk); #1;
      reset        = 1'b0;
      b2.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("no stale beat %0d", i), DW'(b2.out_valid), DW'(0));
      end
      checkOutput("b2 beats after reset", DW'(pops2), DW'(4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tap_bank_select.md
Name: tap_bank_select

Overview:
Registered, parametrised successor to the two-way 4-tap selector. Chooses one of BANKS groups of TAPS samples per beat and forwards it through a valid/ready pipeline stage with a skid buffer. Sits between the pixel/coefficient window generators and the bicubic multiply-accumulate array. Bank choice is either explicit per beat or an automatic round-robin ping-pong.

Parameters:
WIDTH, 17, bits per tap sample
TAPS, 4, samples per bank (one bicubic row or column)
BANKS, 2, number of selectable groups; must be ≥2
AUTO, 0, 0 = bank taken from in_sel each beat; 1 = internal round-robin pointer, in_sel ignored
SEL_W, $clog2(BANKS), select width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  BANKS*TAPS*WIDTH  bank b, tap t at bits [(b*TAPS+t)*WIDTH +: WIDTH]
in_sel  in  SEL_W  bank index for this beat (AUTO=0 only)
in_valid  in  1  upstream beat valid
in_ready  out  1  block can accept a beat
ptr_clr  in  1  synchronous clear of the round-robin pointer (AUTO=1)
out_data  out  TAPS*WIDTH  selected taps, tap t at [t*WIDTH +: WIDTH]
out_bank  out  SEL_W  bank index that produced out_data
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
sel_err  out  1  sticky flag: out-of-range in_sel accepted

Behaviour:
- Reset is asynchronous and active-high. While asserted: out_valid=0, out_data=0, out_bank=0, sel_err=0, skid empty, in_ready=0, round-robin pointer=0. in_ready goes to 1 on the first clk edge after reset deasserts.
- Accept: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready.
- Latency: exactly 1 cycle from accept to out_valid when the output is empty or draining. No combinational path from in_* to out_*, and none from out_ready to in_ready. in_ready is a registered signal equal to "skid empty".
- Storage: main output register plus one skid register.
  - Accept while the output is stalled (out_valid & !out_ready): the beat goes to the skid and in_ready drops next cycle.
  - Skid full and output transfers: the skid moves to the output and in_ready returns to 1 next cycle.
  - Order is always preserved. There is no loss or duplication under any valid/ready pattern.
- Bank select is computed at accept time and stored with the beat:
  - AUTO=0: bank = in_sel. If in_sel ≥ BANKS, bank 0 data is forwarded, out_bank=0, and sel_err sets. sel_err clears only by reset.
  - AUTO=1: bank = pointer. The pointer advances by 1 on each accept and wraps from BANKS-1 to 0. in_sel is ignored and sel_err stays 0.
- ptr_clr (AUTO=1):
  - ptr_clr alone: pointer becomes 0 next edge.
  - ptr_clr coincident with an accept: the beat uses the current pointer and the pointer becomes 0 afterward, so clear wins over increment.
  - ptr_clr has no effect on data already buffered.
- Reset mid-operation: buffered beats are discarded and there is no partial output. All outputs return to their reset values immediately.
- Width: data is passed through unmodified. There is no sign extension or arithmetic.

Decomposition:
- Shared package: the SEL_W derivation function and the tap/bank slice index helpers, so producers and consumers agree on the packing order.
- One natural sub-module: skid_reg, a generic WIDTH-parametrised 2-entry valid/ready skid buffer. It carries {out_bank, out_data}.
- Bank mux and pointer logic stay in the top level.

Test Plan:
- Reset release, AUTO=0, BANKS=2: in_sel=1, bank1 taps = 0x00011/0x00022/0x00033/0x00044, out_ready=1 → out_valid the next cycle with those taps, out_bank=1, sel_err=0.
- Back-pressure: hold out_ready=0 and offer 3 beats (A,B,C) → A held at the output, B in the skid, in_ready=0 and C not accepted. Release out_ready → A, B, C delivered in order with no gaps.
- AUTO=1, BANKS=3: 7 consecutive accepts → out_bank sequence 0,1,2,0,1,2,0. ptr_clr asserted with the 5th accept → sequence 0,1,2,0,1,0,1.
- AUTO=0, BANKS=3: in_sel=3 → bank 0 data out, out_bank=0, sel_err=1 and it stays 1 after later legal beats.
- Random in_valid/out_ready at 50% density, 1000 beats, BANKS=4, WIDTH=17 → a scoreboard shows exact in-order match and in_ready never depends combinationally on out_ready.
- Reset asserted asynchronously mid-cycle with the skid full → out_valid=0 and out_data=0 immediately, no stale beat after release.
